// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR serializer.
package ddr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DDR_DEFAULT_WIDTH = 8;
  localparam logic DDR_IDLE_LEVEL    = 1'b0;

  // Width of the beat counter for a word of the given width (never below 1 bit).
  function automatic int beats_cnt_w(input int width);
    int w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ddr_serializer.sv
// Parallel-to-DDR gearbox feeding an oddr primitive: one WIDTH-bit word
// in per handshake, two bits (D0 rising half, D1 falling half) out per cycle.
//
// state | meaning
// IDLE  | no word in flight, D0/D1 hold IDLE_LEVEL
// SHIFT | word in flight, beat counts the pair currently on D0/D1
module ddr_serializer
  import ddr_pkg::*;
#(
  parameter int   WIDTH      = DDR_DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DDR_IDLE_LEVEL
) (
  input  logic             SCLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             D0,
  output logic             D1,
  output logic             WORD_START,
  output logic             BUSY
);

  localparam int BEATS = WIDTH / 2;
  localparam int BW    = beats_cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("ddr_serializer: WIDTH must be even and >= 4");
  end

  state_t           state;
  logic [BW-1:0]    beat;
  logic             rdy_en;
  logic [WIDTH-3:0] shreg;
  logic [WIDTH-1:0] ordered;
  logic             accept;

  // Put the word in wire order so the shifter always works MSB-first.
  always_comb begin
    ordered = DATA;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        ordered[i] = DATA[WIDTH-1-i];
      end
    end
  end

  // READY depends only on registers; the last beat can take the next word.
  always_comb begin
    READY  = rdy_en && ((state == IDLE) || (beat == LAST_BEAT));
    accept = VALID && READY;
  end

  // Load, shift and return-to-idle sequencing of the output pair.
  always_ff @(posedge SCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      beat       <= '0;
      rdy_en     <= 1'b0;
      shreg      <= '0;
      D0         <= IDLE_LEVEL;
      D1         <= IDLE_LEVEL;
      WORD_START <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        D0         <= ordered[WIDTH-1];
        D1         <= ordered[WIDTH-2];
        shreg      <= ordered[WIDTH-3:0];
        beat       <= '0;
        state      <= SHIFT;
        WORD_START <= 1'b1;
        BUSY       <= 1'b1;
      end else if ((state == SHIFT) && (beat != LAST_BEAT)) begin
        D0         <= shreg[WIDTH-3];
        D1         <= shreg[WIDTH-4];
        shreg      <= shreg << 2;
        beat       <= beat + BW'(1);
        WORD_START <= 1'b0;
      end else begin
        D0         <= IDLE_LEVEL;
        D1         <= IDLE_LEVEL;
        state      <= IDLE;
        WORD_START <= 1'b0;
        BUSY       <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ddr_serializer.md
Name: ddr_serializer

Overview:
Parallel-to-DDR gearbox that sits directly upstream of the oddr output primitive. It accepts WIDTH-bit words over a valid/ready handshake. It emits two bits per SCLK cycle on D0 (rising-half bit) and D1 (falling-half bit), which the parent wires straight into oddr. When no word is pending, the line holds a fixed idle level. Back-to-back words stream with no gap cycles.

Parameters:
- WIDTH, 8: word width in bits; must be even and >= 4 (elaboration error otherwise).
- MSB_FIRST, 1: 1 = DATA[WIDTH-1] is sent first; 0 = DATA[0] is sent first.
- IDLE_LEVEL, 1'b0: value driven on both D0 and D1 when no word is in flight.

Ports:
- SCLK  in  1  Single clock; the same clock that drives the downstream oddr SCLK.
- RST_N  in  1  Asynchronous, active-low reset.
- DATA  in  WIDTH  Word to serialize; sampled on the accepting edge only.
- VALID  in  1  DATA is valid; must hold with DATA stable until accepted.
- READY  out  1  Block will accept DATA at the next rising SCLK if VALID=1.
- D0  out  1  Bit for the rising half of the next cycle; drives oddr D0.
- D1  out  1  Bit for the falling half of the next cycle; drives oddr D1.
- WORD_START  out  1  High for the single cycle in which D0/D1 carry a word's first bit pair.
- BUSY  out  1  High while a word is being shifted out (state SHIFT).

Behaviour:
- Clock and reset: one clock, SCLK, rising-edge only. RST_N is asynchronous and active-low.
- Reset values while RST_N=0: D0=D1=IDLE_LEVEL, WORD_START=0, BUSY=0, READY=0, state=IDLE, beat=0.
- Registered flag rdy_en: cleared by reset, set at the first SCLK edge after RST_N deasserts. READY is gated by rdy_en.
- BEATS = WIDTH/2. Beat counter width = clog2(BEATS), minimum 1 bit.
- States: IDLE, SHIFT. All outputs are registered except READY.
- READY = rdy_en && (state==IDLE || beat==BEATS-1), combinational from registers only, with no path from VALID.
- Accept occurs on a rising SCLK edge where VALID && READY. At that edge:
  - D0/D1 load the first pair.
  - The remaining WIDTH-2 bits load the shift register.
  - beat <= 0, state <= SHIFT, WORD_START <= 1, BUSY <= 1.
- Latency: the first pair is on D0/D1 in the cycle immediately after the accept edge. The word occupies exactly BEATS consecutive cycles.
- Pair ordering:
  - MSB_FIRST=1: pair k is D0=DATA[WIDTH-1-2k], D1=DATA[WIDTH-2-2k].
  - MSB_FIRST=0: pair k is D0=DATA[2k], D1=DATA[2k+1].
  - D0 is always the earlier bit on the wire.
- In SHIFT with beat<BEATS-1: shift the next pair out, beat <= beat+1, WORD_START <= 0.
- In SHIFT with beat==BEATS-1:
  - If VALID: accept the new word (same actions as above). The stream continues with no idle gap and WORD_START pulses again.
  - Otherwise: D0=D1 <= IDLE_LEVEL, state <= IDLE, BUSY <= 0, WORD_START <= 0.
- In IDLE with no VALID: D0=D1 hold IDLE_LEVEL.
- DATA is ignored in every cycle except the accepting edge. Changing DATA mid-word has no effect on the word in flight.
- VALID dropping mid-word does not abort the word in flight.
- Reset mid-word: outputs go to reset values immediately (asynchronously). The partial word is discarded, with no resume after release.
- Boundary case WIDTH=4: BEATS=2, and READY is high in every SHIFT cycle with beat=1.

Decomposition:
- Package ddr_pkg holds:
  - state enum {IDLE, SHIFT};
  - DDR_DEFAULT_WIDTH=8;
  - DDR_IDLE_LEVEL=1'b0;
  - function beats_cnt_w(width) returning clog2(width/2), minimum 1.
- No internal sub-module.
- Parent wrapper ddr_tx_lane instantiates ddr_serializer plus oddr, connecting D0/D1/SCLK.

Test Plan:
- Reset:
  - Hold RST_N=0 with VALID=1 -> READY=0, D0=D1=0, BUSY=0.
  - Release -> READY rises one cycle after the first post-release edge.
  - No word is accepted before then.
- Single word, WIDTH=8, MSB_FIRST=1, DATA=8'hA5, one VALID pulse:
  - Next 4 cycles (D0,D1) = (1,0),(1,0),(0,1),(0,1).
  - WORD_START=1 only in cycle 1, BUSY=1 for 4 cycles, then D0=D1=0.
- Back-to-back, VALID held with 8'hA5 then 8'h3C:
  - 8 contiguous pairs: (1,0),(1,0),(0,1),(0,1),(0,0),(1,1),(1,1),(0,0).
  - READY high in cycles 4 and 8, WORD_START in cycles 1 and 5, no idle gap.
- LSB-first, MSB_FIRST=0, DATA=8'h01 -> pairs (1,0),(0,0),(0,0),(0,0).
- Reset mid-word: assert RST_N=0 during beat 2 of 8'hFF -> D0=D1=0 and BUSY=0 immediately, with no resumed bits after release.
- Idle level and minimum width: IDLE_LEVEL=1, WIDTH=4, DATA=4'b0110:
  - Pairs (0,1),(1,0), then D0=D1=1.
  - READY=1 during beat 1.
